ram_access_ctrl: RTL and testbench

//  Sequences and arbitrates the shared data RAM between the AVR core (CPU) and a DMA master.

---
 rtl/ram_ctrl_pkg.sv | 14 +
 rtl/ram_ws_counter.sv | 28 ++
 rtl/ram_access_ctrl.sv | 125 ++++++++++++
 tb/tb_ram_access_ctrl.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/ram_ctrl_pkg.sv
// Shared encodings for the data-RAM access controller: FSM states and access owners.
package ram_ctrl_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_t;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DMA = 1'b1
  } owner_t;

endpackage

// File: rtl/ram_ws_counter.sv
// Loadable wait-state down-counter; o_zero flags the final cycle of an access.
// Load takes priority over decrement and the count saturates at zero.
module ram_ws_counter #(
  parameter int W = 3
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/ram_access_ctrl.sv
// Arbitrates the shared data RAM between CPU and DMA with ws_cfg+1 access cycles after grant.
// cpuwait stalls the CPU until its completion cycle; DMA holds dma_req until the dma_ack pulse.
module ram_access_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int AW   = 16,
  parameter int DW   = 8,
  parameter int WS_W = 3
) (
  input  logic            cp2,
  input  logic            ireset,
  input  logic [WS_W-1:0] ws_cfg,
  input  logic            cpu_req,
  input  logic            cpu_we,
  input  logic [AW-1:0]   cpu_adr,
  input  logic [DW-1:0]   cpu_dout,
  output logic            cpuwait,
  input  logic            dma_req,
  input  logic            dma_we,
  input  logic [AW-1:0]   dma_adr,
  input  logic [DW-1:0]   dma_dout,
  output logic            dma_gnt,
  output logic            dma_ack,
  output logic [AW-1:0]   ram_adr,
  output logic [DW-1:0]   ram_dout,
  output logic            ram_we,
  output logic            ram_re,
  input  logic [DW-1:0]   ram_din
);

  state_t        r_state;
  state_t        w_state_nxt;
  owner_t        r_owner;
  owner_t        r_last_owner;
  owner_t        w_ref_owner;
  owner_t        w_gnt_owner;
  logic          r_we;
  logic [AW-1:0] r_adr;
  logic [DW-1:0] r_dout;
  logic          w_cnt_zero;
  logic          w_done;
  logic          w_cpu_cand;
  logic          w_dma_cand;
  logic          w_grant;
  logic          w_unused;

  // Read data goes straight from the RAM to the data register and the DMA.
  assign w_unused = ^ram_din;

  assign w_done = (r_state == ST_ACCESS) && w_cnt_zero;

  // The finishing owner's own request is the one being served, so it is masked at completion.
  always_comb begin
    w_ref_owner = r_last_owner;
    w_cpu_cand  = cpu_req;
    w_dma_cand  = dma_req;
    w_grant     = 1'b0;
    w_gnt_owner = OWN_CPU;
    w_state_nxt = r_state;
    if (r_state == ST_ACCESS) begin
      w_ref_owner = r_owner;
      w_cpu_cand  = w_done && cpu_req && (r_owner != OWN_CPU);
      w_dma_cand  = w_done && dma_req && (r_owner != OWN_DMA);
    end
    w_grant = w_cpu_cand || w_dma_cand;
    if (w_cpu_cand && w_dma_cand) begin
      w_gnt_owner = (w_ref_owner == OWN_CPU) ? OWN_DMA : OWN_CPU;
    end else if (w_dma_cand) begin
      w_gnt_owner = OWN_DMA;
    end
    if (w_grant) begin
      w_state_nxt = ST_ACCESS;
    end else if (w_done) begin
      w_state_nxt = ST_IDLE;
    end
  end

  always_ff @(posedge cp2) begin
    if (ireset) begin
      r_state      <= ST_IDLE;
      r_owner      <= OWN_CPU;
      r_last_owner <= OWN_DMA;
      r_we         <= 1'b0;
      r_adr        <= '0;
      r_dout       <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_done) begin
        r_last_owner <= r_owner;
      end
      if (w_grant) begin
        r_owner <= w_gnt_owner;
        if (w_gnt_owner == OWN_DMA) begin
          r_we   <= dma_we;
          r_adr  <= dma_adr;
          r_dout <= dma_dout;
        end else begin
          r_we   <= cpu_we;
          r_adr  <= cpu_adr;
          r_dout <= cpu_dout;
        end
      end
    end
  end

  ram_ws_counter #(
    .W(WS_W)
  ) u_ws_counter (
    .i_clk      (cp2),
    .i_rst      (ireset),
    .i_load     (w_grant),
    .i_load_val (ws_cfg),
    .i_dec      (r_state == ST_ACCESS),
    .o_zero     (w_cnt_zero)
  );

  assign cpuwait  = cpu_req && !(w_done && (r_owner == OWN_CPU));
  assign dma_gnt  = (r_state == ST_ACCESS) && (r_owner == OWN_DMA);
  assign dma_ack  = w_done && (r_owner == OWN_DMA);
  assign ram_we   = (r_state == ST_ACCESS) && r_we;
  assign ram_re   = (r_state == ST_ACCESS) && !r_we;
  assign ram_adr  = r_adr;
  assign ram_dout = r_dout;

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Directed bench for ram_access_ctrl: inputs change 1ns after the rising edge, outputs are checked 1ns later.
module tb_ram_access_ctrl;

  logic        cp2 = 1'b0;
  logic        ireset;
  logic [2:0]  ws_cfg;
  logic        cpu_req, cpu_we, dma_req, dma_we;
  logic [15:0] cpu_adr, dma_adr, ram_adr;
  logic [7:0]  cpu_dout, dma_dout, ram_dout, ram_din;
  logic        cpuwait, dma_gnt, dma_ack, ram_we, ram_re;

  int checks = 0;
  int errors = 0;

  always #5 cp2 = ~cp2;

  ram_access_ctrl #(.AW(16), .DW(8), .WS_W(3)) dut (
    .cp2(cp2), .ireset(ireset), .ws_cfg(ws_cfg),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_adr(cpu_adr), .cpu_dout(cpu_dout), .cpuwait(cpuwait),
    .dma_req(dma_req), .dma_we(dma_we), .dma_adr(dma_adr), .dma_dout(dma_dout),
    .dma_gnt(dma_gnt), .dma_ack(dma_ack),
    .ram_adr(ram_adr), .ram_dout(ram_dout), .ram_we(ram_we), .ram_re(ram_re), .ram_din(ram_din)
  );

  task automatic tick();
    @(posedge cp2);
    #1;
  endtask

  task automatic apply_reset();
    ireset = 1'b1;
    cpu_req = 1'b0; dma_req = 1'b0;
    tick(); tick();
    ireset = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    ireset = 1'b1; ws_cfg = 3'd0; ram_din = 8'h00;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_adr = 16'h0; cpu_dout = 8'h0;
    dma_req = 1'b0; dma_we = 1'b0; dma_adr = 16'h0; dma_dout = 8'h0;
    tick(); tick();
    #1;
    checks++; if ({ram_we, ram_re, dma_gnt, dma_ack, cpuwait} !== 5'b0) begin errors++;
      $display("FAIL reset_strobes got=%b exp=00000", {ram_we, ram_re, dma_gnt, dma_ack, cpuwait}); end
    checks++; if ({ram_adr, ram_dout} !== 24'h0) begin errors++;
      $display("FAIL reset_adr_dout got=%h exp=000000", {ram_adr, ram_dout}); end
    ireset = 1'b0;
    tick();
  endtask

  task automatic test_cpu_read_ws0();
    ws_cfg = 3'd0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_adr = 16'h0100;
    #1;
    checks++; if ({cpuwait, ram_re} !== 2'b10) begin errors++;
      $display("FAIL t1_grant_cycle got=%b exp=10", {cpuwait, ram_re}); end
    tick();
    checks++; if ({ram_re, ram_we, cpuwait, dma_gnt} !== 4'b1000) begin errors++;
      $display("FAIL t1_access got=%b exp=1000", {ram_re, ram_we, cpuwait, dma_gnt}); end
    checks++; if (ram_adr !== 16'h0100) begin errors++;
      $display("FAIL t1_adr got=%h exp=0100", ram_adr); end
    tick();
    cpu_req = 1'b0;
    #1;
    checks++; if ({ram_re, ram_we} !== 2'b00) begin errors++;
      $display("FAIL t1_idle got=%b exp=00", {ram_re, ram_we}); end
  endtask

  task automatic test_dma_write_ws3();
    int acks = 0;
    ws_cfg = 3'd3;
    dma_req = 1'b1; dma_we = 1'b1; dma_adr = 16'h0200; dma_dout = 8'hA5;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (dma_ack) acks++;
      checks++; if ({ram_we, ram_re, dma_gnt, dma_ack} !== {3'b101, (i == 3)}) begin errors++;
        $display("FAIL t2_cycle%0d got=%b exp=%b", i, {ram_we, ram_re, dma_gnt, dma_ack}, {3'b101, (i == 3)}); end
    end
    checks++; if ({ram_adr, ram_dout} !== 24'h0200A5) begin errors++;
      $display("FAIL t2_adr_dout got=%h exp=0200a5", {ram_adr, ram_dout}); end
    tick();
    dma_req = 1'b0;
    #1;
    if (dma_ack) acks++;
    checks++; if ({ram_we, dma_gnt, acks[1:0]} !== 4'b0001) begin errors++;
      $display("FAIL t2_after got=%b exp=0001", {ram_we, dma_gnt, acks[1:0]}); end
  endtask

  task automatic test_contention_after_reset();
    apply_reset();
    ws_cfg = 3'd0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_adr = 16'h0300;
    dma_req = 1'b1; dma_we = 1'b1; dma_adr = 16'h0400; dma_dout = 8'h5A;
    tick();
    checks++; if ({ram_re, dma_gnt, cpuwait, ram_adr} !== {3'b100, 16'h0300}) begin errors++;
      $display("FAIL t3_cpu_first got=%b/%h exp=100/0300", {ram_re, dma_gnt, cpuwait}, ram_adr); end
    tick();
    cpu_req = 1'b0;
    #1;
    checks++; if ({ram_we, dma_gnt, dma_ack, ram_adr, ram_dout} !== {3'b111, 16'h0400, 8'h5A}) begin errors++;
      $display("FAIL t3_dma_b2b got=%b/%h/%h exp=111/0400/5a", {ram_we, dma_gnt, dma_ack}, ram_adr, ram_dout); end
    tick();
    dma_req = 1'b0;
    #1;
    checks++; if ({ram_we, ram_re, dma_gnt} !== 3'b000) begin errors++;
      $display("FAIL t3_idle got=%b exp=000", {ram_we, ram_re, dma_gnt}); end
  endtask

  task automatic test_round_robin();
    logic own_dma, last;
    ws_cfg = 3'd1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_adr = 16'h0010;
    dma_req = 1'b1; dma_we = 1'b1; dma_adr = 16'h0020; dma_dout = 8'h77;
    for (int k = 0; k < 12; k++) begin
      tick();
      own_dma = ((k / 2) % 2) == 1;
      last = (k % 2) == 1;
      checks++;
      if ({dma_gnt, ram_we, ram_re, dma_ack, cpuwait} !== {own_dma, own_dma, !own_dma, own_dma && last, !(!own_dma && last)}) begin
        errors++;
        $display("FAIL t4_cycle%0d got=%b exp=%b", k, {dma_gnt, ram_we, ram_re, dma_ack, cpuwait},
                 {own_dma, own_dma, !own_dma, own_dma && last, !(!own_dma && last)});
      end
    end
    cpu_req = 1'b0; dma_req = 1'b0;
    tick();
    checks++; if ({ram_we, ram_re, dma_gnt} !== 3'b000) begin errors++;
      $display("FAIL t4_idle got=%b exp=000", {ram_we, ram_re, dma_gnt}); end
  endtask

  task automatic test_reset_mid_access();
    logic seen_ack = 1'b0;
    ws_cfg = 3'd5;
    dma_req = 1'b1; dma_we = 1'b1; dma_adr = 16'h0BEE; dma_dout = 8'h3C;
    tick(); tick();
    checks++; if ({dma_gnt, ram_we, dma_ack} !== 3'b110) begin errors++;
      $display("FAIL t5_in_access got=%b exp=110", {dma_gnt, ram_we, dma_ack}); end
    ireset = 1'b1;
    tick();
    checks++; if ({ram_we, ram_re, dma_gnt, dma_ack, ram_adr, ram_dout} !== 28'h0) begin errors++;
      $display("FAIL t5_after_reset got=%b/%h/%h exp=0000/0000/00", {ram_we, ram_re, dma_gnt, dma_ack}, ram_adr, ram_dout); end
    ireset = 1'b0; dma_req = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (dma_ack || dma_gnt) seen_ack = 1'b1;
    end
    checks++; if (seen_ack !== 1'b0) begin errors++;
      $display("FAIL t5_no_ack got=%b exp=0", seen_ack); end
  endtask

  task automatic test_ws_change_mid_access();
    apply_reset();
    ws_cfg = 3'd2;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_adr = 16'h0500; cpu_dout = 8'h33;
    tick();
    ws_cfg = 3'd0;
    dma_req = 1'b1; dma_we = 1'b0; dma_adr = 16'h0600;
    #1;
    checks++; if ({ram_we, cpuwait, dma_gnt} !== 3'b110) begin errors++;
      $display("FAIL t6_c1 got=%b exp=110", {ram_we, cpuwait, dma_gnt}); end
    tick();
    checks++; if ({ram_we, cpuwait, dma_gnt} !== 3'b110) begin errors++;
      $display("FAIL t6_c2 got=%b exp=110", {ram_we, cpuwait, dma_gnt}); end
    tick();
    checks++; if ({ram_we, cpuwait, dma_gnt, ram_dout} !== {3'b100, 8'h33}) begin errors++;
      $display("FAIL t6_c3 got=%b/%h exp=100/33", {ram_we, cpuwait, dma_gnt}, ram_dout); end
    tick();
    cpu_req = 1'b0;
    #1;
    checks++; if ({ram_re, dma_gnt, dma_ack, ram_adr} !== {3'b111, 16'h0600}) begin errors++;
      $display("FAIL t6_dma_ws0 got=%b/%h exp=111/0600", {ram_re, dma_gnt, dma_ack}, ram_adr); end
    tick();
    dma_req = 1'b0;
    #1;
    checks++; if ({ram_re, ram_we, dma_gnt, dma_ack} !== 4'b0000) begin errors++;
      $display("FAIL t6_idle got=%b exp=0000", {ram_re, ram_we, dma_gnt, dma_ack}); end
  endtask

  initial begin
    test_reset();
    test_cpu_read_ws0();
    test_dma_write_ws3();
    test_contention_after_reset();
    test_round_robin();
    test_reset_mid_access();
    test_ws_change_mid_access();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
